weapon_controller: RTL and testbench

WEAPON_CONTROLLER -- requirements
Module: weapon_controller

---
 rtl/weapon_pkg.sv | 27 ++
 rtl/rise_edge.sv | 18 +
 rtl/weapon_controller.sv | 118 +++++++++++
 tb/tb_weapon_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weapon_pkg.sv
// Shared weapon definitions: FSM state encoding and the one-hot fire_state codes
// that enemy_controller decodes.
package weapon_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_LOADED,
        ST_FIRED,
        ST_COOLDOWN,
        ST_EMPTY,
        ST_RELOADING
    } state_t;

    localparam logic [2:0] FIRE_LOADED = 3'b001;
    localparam logic [2:0] FIRE_FIRED  = 3'b010;
    localparam logic [2:0] FIRE_IDLE   = 3'b100;

    // Maps a state onto the code presented to enemy_controller.
    function automatic logic [2:0] fire_code(input state_t s);
        case (s)
            ST_LOADED: return FIRE_LOADED;
            ST_FIRED:  return FIRE_FIRED;
            default:   return FIRE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one history register, edge = level & ~previous level.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic edge_o
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level_i;
    end

    assign edge_o = level_i & ~level_q;

endmodule

// File: rtl/weapon_controller.sv
// Weapon FSM: arm on start, fire/cooldown per shot, reload from empty or tactically.
// Optional WEAPON_AUTOFIRE_EN: a held trigger refires whenever the weapon is loaded.
import weapon_pkg::*;

module weapon_controller #(
    parameter int MAG_SIZE     = 3,
    parameter int COOL_TICKS   = 1,
    parameter int RELOAD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       start,
    input  logic       game_over,
    input  logic       fire_btn,
    input  logic       reload_btn,
    output logic [2:0] fire_state,
    output logic [3:0] ammo,
    output logic       empty_flag
);

    localparam logic [3:0] MAG         = 4'(MAG_SIZE);
    localparam logic [2:0] COOL_LAST   = 3'(COOL_TICKS - 1);
    localparam logic [2:0] RELOAD_LAST = 3'(RELOAD_TICKS - 1);

    state_t     state_q, state_d;
    logic [3:0] ammo_q, ammo_d;
    logic [2:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] fire_state_q;
    logic       empty_q;
    logic       start_edge, fire_edge, reload_edge, fire_trig;

    rise_edge u_start_edge  (.clk(clk), .rst(rst), .level_i(start),      .edge_o(start_edge));
    rise_edge u_fire_edge   (.clk(clk), .rst(rst), .level_i(fire_btn),   .edge_o(fire_edge));
    rise_edge u_reload_edge (.clk(clk), .rst(rst), .level_i(reload_btn), .edge_o(reload_edge));

`ifdef WEAPON_AUTOFIRE_EN
    assign fire_trig = fire_btn;
`else
    assign fire_trig = fire_edge;
`endif

    // The shared tick counter is cleared on every entry into COOLDOWN or RELOADING,
    // so a tick landing on the entry clock is never credited to the new state.
    always_comb begin
        state_d    = state_q;
        ammo_d     = ammo_q;
        tick_cnt_d = tick_cnt_q;
        if (game_over) begin
            state_d    = ST_DISARMED;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                ST_DISARMED: if (start_edge) begin
                    state_d = ST_LOADED;
                    ammo_d  = MAG;
                end
                ST_LOADED: begin
                    if (fire_trig && ammo_q != 4'd0) begin
                        state_d = ST_FIRED;
                        ammo_d  = ammo_q - 4'd1;
                    end else if (reload_edge && ammo_q < MAG) begin
                        state_d    = ST_RELOADING;
                        tick_cnt_d = '0;
                    end
                end
                ST_FIRED: begin
                    state_d    = (ammo_q != 4'd0) ? ST_COOLDOWN : ST_EMPTY;
                    tick_cnt_d = '0;
                end
                ST_COOLDOWN: if (sec_tick) begin
                    if (tick_cnt_q == COOL_LAST) begin
                        state_d    = ST_LOADED;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 3'd1;
                    end
                end
                ST_EMPTY: if (reload_edge) begin
                    state_d    = ST_RELOADING;
                    tick_cnt_d = '0;
                end
                ST_RELOADING: if (sec_tick) begin
                    if (tick_cnt_q == RELOAD_LAST) begin
                        state_d    = ST_LOADED;
                        ammo_d     = MAG;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 3'd1;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    // Outputs are registered from the next state so they change cleanly with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DISARMED;
            ammo_q       <= 4'd0;
            tick_cnt_q   <= 3'd0;
            fire_state_q <= FIRE_IDLE;
            empty_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ammo_q       <= ammo_d;
            tick_cnt_q   <= tick_cnt_d;
            fire_state_q <= fire_code(state_d);
            empty_q      <= (state_d == ST_EMPTY);
        end
    end

    assign fire_state = fire_state_q;
    assign ammo       = ammo_q;
    assign empty_flag = empty_q;

endmodule

// File: tb/tb_weapon_controller.sv
// Self-checking bench for weapon_controller: directed scenarios plus random stimulus
// checked against a countdown-based behavioural model of the weapon.
module tb_weapon_controller;

    localparam int MAG    = 3;
    localparam int COOL   = 1;
    localparam int RELOAD = 2;

    localparam int M_OFF = 0, M_READY = 1, M_SHOT = 2, M_COOL = 3, M_EMPTY = 4, M_RELOAD = 5;

    // Stimulus vector bit masks {fire, reload, start, game_over, tick}
    localparam logic [4:0] F = 5'b10000, R = 5'b01000, S = 5'b00100, G = 5'b00010, T = 5'b00001;

    logic       clk = 1'b0;
    logic       rst, sec_tick, start, game_over, fire_btn, reload_btn;
    logic [2:0] fire_state;
    logic [3:0] ammo;
    logic       empty_flag;
    logic [7:0] dutOut;

    int checks = 0;
    int errors = 0;

    int mMode, mAmmo, mLeft;
    logic pF, pR, pS;

    weapon_controller #(.MAG_SIZE(MAG), .COOL_TICKS(COOL), .RELOAD_TICKS(RELOAD)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .start(start), .game_over(game_over),
        .fire_btn(fire_btn), .reload_btn(reload_btn),
        .fire_state(fire_state), .ammo(ammo), .empty_flag(empty_flag)
    );

    always #5 clk = ~clk;

    assign dutOut = {fire_state, ammo, empty_flag};

    task automatic modelReset();
        mMode = M_OFF; mAmmo = 0; mLeft = 0;
        pF = 1'b0; pR = 1'b0; pS = 1'b0;
    endtask

    // One clock of the weapon rules; ticks count down the remaining seconds.
    task automatic modelStep();
        logic fe, re, se, trig;
        fe = fire_btn & ~pF;
        re = reload_btn & ~pR;
        se = start & ~pS;
`ifdef WEAPON_AUTOFIRE_EN
        trig = fire_btn;
`else
        trig = fe;
`endif
        if (game_over) begin
            mMode = M_OFF; mLeft = 0;
        end else begin
            case (mMode)
                M_OFF:    if (se) begin mMode = M_READY; mAmmo = MAG; end
                M_READY:  if (trig) begin mMode = M_SHOT; mAmmo = mAmmo - 1; end
                          else if (re && mAmmo < MAG) begin mMode = M_RELOAD; mLeft = RELOAD; end
                M_SHOT:   if (mAmmo > 0) begin mMode = M_COOL; mLeft = COOL; end
                          else mMode = M_EMPTY;
                M_COOL:   if (sec_tick) begin
                              mLeft = mLeft - 1;
                              if (mLeft == 0) mMode = M_READY;
                          end
                M_EMPTY:  if (re) begin mMode = M_RELOAD; mLeft = RELOAD; end
                M_RELOAD: if (sec_tick) begin
                              mLeft = mLeft - 1;
                              if (mLeft == 0) begin mAmmo = MAG; mMode = M_READY; end
                          end
                default: ;
            endcase
        end
        pF = fire_btn; pR = reload_btn; pS = start;
    endtask

    function automatic logic [7:0] modelOut();
        logic [2:0] fs;
        fs = (mMode == M_READY) ? 3'b001 : (mMode == M_SHOT) ? 3'b010 : 3'b100;
        return {fs, 4'(mAmmo), 1'(mMode == M_EMPTY)};
    endfunction

    task automatic applyStimulus(input logic [4:0] v);
        {fire_btn, reload_btn, start, game_over, sec_tick} = v;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        logic [4:0] stim [4] = '{F, 5'b0, F | T, 5'b0};
        rst = 1'b1;
        #2;
        modelReset();
        checks++;
        if (dutOut !== 8'b100_0000_0)
            begin errors++; $display("[TB] FAIL reset_state got %b want %b", dutOut, 8'b100_0000_0); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== 8'b100_0000_0)
                begin errors++; $display("[TB] FAIL no_shot_before_start step %0d got %b want %b", i, dutOut, 8'b100_0000_0); end
        end
    endtask

    task automatic test_start();
        logic [4:0] stim [2] = '{S, 5'b0};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== 8'b001_0011_0)
                begin errors++; $display("[TB] FAIL start_load step %0d got %b want %b", i, dutOut, 8'b001_0011_0); end
        end
    endtask

    task automatic test_fire_cooldown();
        logic [4:0] stim [4] = '{F, 5'b0, 5'b0, T};
        logic [7:0] want [4] = '{8'b010_0010_0, 8'b100_0010_0, 8'b100_0010_0, 8'b001_0010_0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL fire_cooldown step %0d got %b want %b", i, dutOut, want[i]); end
        end
    endtask

    task automatic test_empty();
        logic [4:0] stim [8] = '{F, 5'b0, T, F, 5'b0, T, F, 5'b0};
        logic [7:0] want [8] = '{8'b010_0001_0, 8'b100_0001_0, 8'b001_0001_0, 8'b010_0000_0,
                                 8'b100_0000_1, 8'b100_0000_1, 8'b100_0000_1, 8'b100_0000_1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL empty_mag step %0d got %b want %b", i, dutOut, want[i]); end
        end
    endtask

    task automatic test_reload();
        logic [4:0] stim [3] = '{R | T, T, T};
        logic [7:0] want [3] = '{8'b100_0000_0, 8'b100_0000_0, 8'b001_0011_0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL reload step %0d got %b want %b", i, dutOut, want[i]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] stim [3] = '{F | R, 5'b0, T};
        logic [7:0] want [3] = '{8'b010_0010_0, 8'b100_0010_0, 8'b001_0010_0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL fire_beats_reload step %0d got %b want %b", i, dutOut, want[i]); end
        end
    endtask

    task automatic test_game_over();
        logic [4:0] stim [7] = '{R, T, G | T, G | S, 5'b0, S, 5'b0};
        logic [7:0] want [7] = '{8'b100_0010_0, 8'b100_0010_0, 8'b100_0010_0, 8'b100_0010_0,
                                 8'b100_0010_0, 8'b001_0011_0, 8'b001_0011_0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL game_over step %0d got %b want %b", i, dutOut, want[i]); end
        end
    endtask

    task automatic test_held_fire();
        logic [4:0] stim [5] = '{F, F, F | T, F, F};
`ifdef WEAPON_AUTOFIRE_EN
        logic [7:0] want [5] = '{8'b010_0010_0, 8'b100_0010_0, 8'b001_0010_0, 8'b010_0001_0, 8'b100_0001_0};
`else
        logic [7:0] want [5] = '{8'b010_0010_0, 8'b100_0010_0, 8'b001_0010_0, 8'b001_0010_0, 8'b001_0010_0};
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== want[i])
                begin errors++; $display("[TB] FAIL held_fire step %0d got %b want %b", i, dutOut, want[i]); end
        end
        applyStimulus(5'b0);
    endtask

    task automatic test_reset_mid_reload();
        logic [4:0] stim [3] = '{T, R, T};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stim[i]);
            checks++;
            if (dutOut !== modelOut())
                begin errors++; $display("[TB] FAIL pre_reset step %0d got %b want %b", i, dutOut, modelOut()); end
        end
        pulseReset();
        checks++;
        if (dutOut !== 8'b100_0000_0)
            begin errors++; $display("[TB] FAIL reset_mid_reload got %b want %b", dutOut, 8'b100_0000_0); end
        applyStimulus(F | T);
        checks++;
        if (dutOut !== 8'b100_0000_0)
            begin errors++; $display("[TB] FAIL fire_after_reset got %b want %b", dutOut, 8'b100_0000_0); end
        applyStimulus(5'b0);
    endtask

    task automatic test_random();
        logic [4:0] v;
        pulseReset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) pulseReset();
            v[4] = ($urandom_range(0, 1) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = ($urandom_range(0, 7) == 0);
            v[1] = ($urandom_range(0, 39) == 0);
            v[0] = ($urandom_range(0, 2) == 0);
            applyStimulus(v);
            checks++;
            if (dutOut !== modelOut())
                begin errors++; $display("[TB] FAIL random cycle %0d got %b want %b", i, dutOut, modelOut()); end
        end
    endtask

    initial begin
        rst = 1'b1;
        {fire_btn, reload_btn, start, game_over, sec_tick} = 5'b0;
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
        test_start();
        test_fire_cooldown();
        test_empty();
        test_reload();
        test_simultaneous();
        test_game_over();
        test_held_fire();
        test_reset_mid_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
